tone_player: RTL and testbench



---
 rtl/tone_pkg.sv | 24 ++
 rtl/tone_player_pwm_dac.sv | 33 +++
 rtl/tone_player.sv | 175 +++++++++++++++++
 tb/tb_tone_player.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone buffer player.
// Contents: state_t playback states, default address/data widths,
// PWM_MID offset-binary midscale code, to_offset() sign-to-offset helper.
package tone_pkg;

    localparam int unsigned TONE_ADDR_W = 14;
    localparam int unsigned TONE_DATA_W = 16;

    // Offset-binary midscale (signed zero) at full sample width.
    localparam logic [TONE_DATA_W-1:0] PWM_MID = {1'b1, {(TONE_DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        READ      = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    // Signed two's complement to offset binary: invert the MSB.
    function automatic logic [TONE_DATA_W-1:0] to_offset(input logic [TONE_DATA_W-1:0] s);
        return {~s[TONE_DATA_W-1], s[TONE_DATA_W-2:0]};
    endfunction

endpackage

// File: rtl/tone_player_pwm_dac.sv
// 1-bit PWM DAC: free-running counter, duty register reloaded only at counter
// wrap (glitch-free periods), registered comparator output.
// Ports: clk, rst (sync, active-high), duty_in [PWM_W], pwm_out.
module pwm_dac #(
    parameter int unsigned PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty_in,
    output logic             pwm_out
);

    localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_r;

    // Counter, wrap-aligned duty load, output compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            duty_r  <= DUTY_MID;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + PWM_W'(1);
            if (cnt == '1) begin
                duty_r <= duty_in;
            end
            pwm_out <= (cnt < duty_r);
        end
    end

endmodule

// File: rtl/tone_player.sv
// Tone buffer player: fetches signed samples from the tone BRAM once every
// CLK_DIV clocks, presents them as a registered sample stream and drives a
// PWM audio output. Plays the buffer once or loops it.
// Ports: clk, rst (sync, active-high), start/stop pulses, loop, buf_len,
//        BRAM read port (rd_en, rd_addr, rd_data), sample/sample_valid,
//        wrap, done, busy, pwm_out.
// Build option: TONE_PLAYER_VOLUME_EN adds vol[3:0]; the PWM source becomes
//        sample >>> vol, with vol captured alongside each sample.
module tone_player
    import tone_pkg::*;
#(
    parameter int unsigned ADDR_W  = TONE_ADDR_W,
    parameter int unsigned DATA_W  = TONE_DATA_W,
    parameter int unsigned CLK_DIV = 2272,
    parameter int unsigned PWM_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] buf_len,
`ifdef TONE_PLAYER_VOLUME_EN
    input  logic [3:0]        vol,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              wrap,
    output logic              done,
    output logic              busy,
    output logic              pwm_out
);

    localparam int unsigned TICK_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   len_r, len_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [TICK_W-1:0]   tick, tick_d;
    logic [DATA_W-1:0]   sample_d;
    logic                rd_en_d, valid_d, wrap_d, done_d, busy_d;
    logic                tick_last_c;
    logic [DATA_W-1:0]   src_c;
    logic [PWM_W-1:0]    duty_c;

    assign tick_last_c = (tick == TICK_LAST);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len_r        <= '0;
            rd_addr      <= '0;
            tick         <= '0;
            sample       <= '0;
            rd_en        <= 1'b0;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            len_r        <= len_d;
            rd_addr      <= addr_d;
            tick         <= tick_d;
            sample       <= sample_d;
            rd_en        <= rd_en_d;
            sample_valid <= valid_d;
            wrap         <= wrap_d;
            done         <= done_d;
            busy         <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        len_d    = len_r;
        addr_d   = rd_addr;
        sample_d = sample;
        valid_d  = 1'b0;
        wrap_d   = 1'b0;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop && (buf_len != '0)) begin
                    len_d   = buf_len;
                    addr_d  = '0;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                sample_d = rd_data;
                valid_d  = 1'b1;
                if (rd_addr == len_r - ADDR_W'(1)) begin
                    wrap_d = 1'b1;
                    if (loop) begin
                        addr_d  = '0;
                        state_d = tick_last_c ? READ : WAIT_TICK;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    addr_d  = rd_addr + ADDR_W'(1);
                    // With CLK_DIV = 2 the period ends in CAPTURE itself.
                    state_d = tick_last_c ? READ : WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick_last_c) begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards any in-flight fetch and its pulses.
        if (stop && (state != IDLE)) begin
            state_d  = IDLE;
            addr_d   = rd_addr;
            sample_d = sample;
            valid_d  = 1'b0;
            wrap_d   = 1'b0;
            done_d   = 1'b0;
        end

        // Tick is 0 in the READ cycle and counts up to the next READ.
        tick_d  = ((state_d == READ) || (state_d == IDLE)) ? '0 : tick + TICK_W'(1);
        rd_en_d = (state_d == READ);
        busy_d  = (state_d != IDLE);
    end

`ifdef TONE_PLAYER_VOLUME_EN
    logic [3:0] vol_r;

    // Volume is captured together with each sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            vol_r <= '0;
        end else if ((state == CAPTURE) && !stop) begin
            vol_r <= vol;
        end
    end

    assign src_c = DATA_W'($signed(sample) >>> vol_r);
`else
    assign src_c = sample;
`endif

    // Idle player outputs silence (midscale) from the next PWM period on.
    assign duty_c = (state == IDLE)
                  ? PWM_W'(PWM_MID >> (TONE_DATA_W - PWM_W))
                  : PWM_W'(to_offset(TONE_DATA_W'(src_c)) >> (TONE_DATA_W - PWM_W));

    pwm_dac #(
        .PWM_W (PWM_W)
    ) u_pwm_dac (
        .clk     (clk),
        .rst     (rst),
        .duty_in (duty_c),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player (CLK_DIV = 8, PWM_W = 8) with a
// 1-cycle-latency BRAM model. Expected playback timing is derived per cycle
// from the fetch schedule: fetch k reads at cycle 1+k*D and delivers at 3+k*D.
module tb_tone_player;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;
    localparam int          D  = 8;

    logic          clk = 1'b0;
    logic          rst, start, stop, loop;
    logic [AW-1:0] buf_len;
`ifdef TONE_PLAYER_VOLUME_EN
    logic [3:0]    vol;
`endif
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] sample;
    logic          sample_valid, wrap, done, busy, pwm_out;

    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] exp_sample;
    int            checks = 0;
    int            errors = 0;
    int            wrap_seen;

    tone_player #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .CLK_DIV (D),
        .PWM_W   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .buf_len      (buf_len),
`ifdef TONE_PLAYER_VOLUME_EN
        .vol          (vol),
`endif
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .done         (done),
        .busy         (busy),
        .pwm_out      (pwm_out)
    );

    always #5 clk = ~clk;

    // BRAM model: data valid one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[5:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_valid"}, 32'(sample_valid), 32'd0);
    endtask

    // One playback from a start pulse; tstop/tn = cycle of stop / stray start (0 = none).
    task automatic run(input int len, input bit lp, input int tstop, input int tn);
        int  t_end, tlast, k, j, jaddr;
        bit  alive, e_rd, e_sv, e_wrap, e_busy;
        wrap_seen = 0;
        @(negedge clk);
        buf_len = AW'(len);
        loop    = lp;
        start   = 1'b1;
        t_end   = lp ? 0 : 3 + (len - 1) * D;
        tlast   = (tstop > 0) ? tstop + 3 : t_end + 3;
        for (int t = 1; t <= tlast; t++) begin
            @(negedge clk);
            start   = 1'b0;
            stop    = 1'b0;
            buf_len = AW'(len);
            alive   = (tstop == 0) || (t <= tstop);
            k       = (t - 1) / D;
            e_rd    = alive && ((t - 1) % D == 0) && (lp || k < len);
            e_sv    = 1'b0;
            e_wrap  = 1'b0;
            if (t >= 3 && ((t - 3) % D == 0)) begin
                j = (t - 3) / D;
                if (alive && (lp || j < len)) begin
                    jaddr      = lp ? j % len : j;
                    e_sv       = 1'b1;
                    e_wrap     = (jaddr == len - 1);
                    exp_sample = mem[jaddr];
                end
            end
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            if (e_rd) chk("rd_addr", 32'(rd_addr), lp ? 32'(k % len) : 32'(k));
            chk("sample_valid", 32'(sample_valid), 32'(e_sv));
            chk("sample", 32'(sample), 32'(exp_sample));
            chk("wrap", 32'(wrap), 32'(e_wrap));
            chk("done", 32'(done), 32'(e_wrap && !lp));
            if (wrap) wrap_seen++;
            e_busy = alive && (lp || t < t_end);
            if (lp || !alive || t != t_end) chk("busy", 32'(busy), 32'(e_busy));
            if (t == tstop) stop = 1'b1;
            if (t == tn) begin
                start   = 1'b1;
                buf_len = AW'($urandom_range(1, 60));
            end
        end
        stop = 1'b0;
    endtask

    // Hold a constant code via a 1-sample looping buffer and count PWM highs.
    task automatic pwm_case(input logic [DW-1:0] code, input int exp_high, input string tag);
        int highs;
        mem[0] = code;
        @(negedge clk);
        buf_len = AW'(1);
        loop    = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (600) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_out) highs++;
        end
        chk(tag, 32'(highs), 32'(exp_high));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        exp_sample = code;
        chk({tag, "_sample"}, 32'(sample), 32'(code));
    endtask

    initial begin
        int len, tstop, tn, lim;
        bit lp;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; buf_len = '0;
`ifdef TONE_PLAYER_VOLUME_EN
        vol = 4'd0;
`endif
        for (int i = 0; i < 64; i++) mem[i] = DW'(i * 16'h0100);
        exp_sample = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        rst = 1'b0;

        // Play once, 4 samples.
        run(4, 1'b0, 0, 0);
        chk("once_wraps", 32'(wrap_seen), 32'd1);
        // Loop 3 samples, stop after the 7th delivery.
        run(3, 1'b1, 3 + 6 * D, 0);
        chk("loop_wraps", 32'(wrap_seen), 32'd2);
        // Stop in the 3rd rd_en cycle.
        run(4, 1'b0, 1 + 2 * D, 0);
        chk("stop_hold", 32'(sample), 32'h0100);
        // Stray start while busy.
        run(5, 1'b0, 0, D + 2);

        // start + stop together from IDLE.
        @(negedge clk);
        buf_len = AW'(4); start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            chk_idle("startstop");
        end
        // start with buf_len = 0.
        @(negedge clk);
        buf_len = '0; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk_idle("len0");
        end

        // Randomized buffers, lengths, modes, stops and stray starts.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
            len = $urandom_range(1, 6);
            lp  = 1'($urandom_range(0, 1));
            if (lp) tstop = $urandom_range(1, 7 * D);
            else    tstop = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3 + (len - 1) * D) : 0;
            lim = lp ? 1000 : 2 + (len - 1) * D;
            if (tstop > 0 && tstop < lim) lim = tstop;
            tn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lim) : 0;
            run(len, lp, tstop, tn);
        end

        // PWM duty mapping.
        pwm_case(16'h8000, 0, "pwm_min");
        pwm_case(16'h0000, 128, "pwm_zero");
        pwm_case(16'h7FFF, 255, "pwm_max");
`ifdef TONE_PLAYER_VOLUME_EN
        vol = 4'd1;
        pwm_case(16'h4000, 160, "pwm_vol");
        vol = 4'd0;
`endif

        // Reset in the middle of a looping playback.
        @(negedge clk);
        buf_len = AW'(3); loop = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (D + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_sample", 32'(sample), 32'd0);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_pwm", 32'(pwm_out), 32'd0);
        rst = 1'b0;
        exp_sample = '0;
        repeat (D) @(negedge clk);
        chk_idle("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
